// File: rtl/aes_job_sequencer.sv
// Job sequencer for the AES serial coprocessor: one frame in, optional key
// expansion, encrypt/decrypt, output select, serial write-back, with per-stage watchdog.
module aes_job_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ReadRy,
  input  logic             ProgramSelector,
  input  logic             KeyNew,
  input  logic             KeyRy,
  input  logic             EncRy,
  input  logic             DecRy,
  input  logic             OutRy,
  input  logic             SerialWriteRy,
  input  logic             ClrErr,
  output logic             SerialReadEn,
  output logic             KeyEn,
  output logic             EncEn,
  output logic             DecEn,
  output logic             OutEn,
  output logic             SerialWriteEn,
  output logic             ModeLatched,
  output logic             KeyValid,
  output logic             Busy,
  output logic             Error,
  output logic [CNT_W-1:0] JobCount
);

  localparam int unsigned WD_W = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_KEY, S_CRYPT, S_OUT, S_WRITE, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             mode_q, mode_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
  logic             read_en_q, read_en_d;
  logic             key_en_q, key_en_d;
  logic             enc_en_q, enc_en_d;
  logic             dec_en_q, dec_en_d;
  logic             out_en_q, out_en_d;
  logic             write_en_q, write_en_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic             wd_expired;

  assign wd_expired = (wd_q == WD_LAST);

  // Next-state and next-output logic; a Ry arriving in the watchdog's last cycle wins.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    key_valid_d = key_valid_q;
    job_cnt_d   = job_cnt_q;

    case (state_q)
      S_IDLE: state_d = S_READ;
      S_READ: begin
        if (ReadRy) begin
          mode_d = ProgramSelector;
          if (KeyNew) key_valid_d = 1'b0;
          state_d = (KeyNew || !key_valid_q) ? S_KEY : S_CRYPT;
        end
      end
      S_KEY: begin
        if (KeyRy) begin
          key_valid_d = 1'b1;
          state_d     = S_CRYPT;
        end else if (wd_expired) begin
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_CRYPT: begin
        if (mode_q ? DecRy : EncRy) begin
          state_d = S_OUT;
        end else if (wd_expired) begin
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_OUT: begin
        if (OutRy) begin
          state_d = S_WRITE;
        end else if (wd_expired) begin
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_WRITE: begin
        if (SerialWriteRy) begin
          job_cnt_d = job_cnt_q + CNT_W'(1);
          state_d   = S_READ;
        end else if (wd_expired) begin
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_ERR: begin
        if (ClrErr) state_d = S_READ;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change.
    wd_d = (state_d != state_q) ? '0 : wd_q + WD_W'(1);

    read_en_d  = (state_d == S_READ);
    key_en_d   = (state_d == S_KEY);
    enc_en_d   = (state_d == S_CRYPT) && !mode_d;
    dec_en_d   = (state_d == S_CRYPT) && mode_d;
    out_en_d   = (state_d == S_OUT);
    write_en_d = (state_d == S_WRITE);
    busy_d     = key_en_d || (state_d == S_CRYPT) || out_en_d || write_en_d;
    error_d    = (state_d == S_ERR);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
      job_cnt_q   <= '0;
      read_en_q   <= 1'b0;
      key_en_q    <= 1'b0;
      enc_en_q    <= 1'b0;
      dec_en_q    <= 1'b0;
      out_en_q    <= 1'b0;
      write_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      mode_q      <= mode_d;
      key_valid_q <= key_valid_d;
      job_cnt_q   <= job_cnt_d;
      read_en_q   <= read_en_d;
      key_en_q    <= key_en_d;
      enc_en_q    <= enc_en_d;
      dec_en_q    <= dec_en_d;
      out_en_q    <= out_en_d;
      write_en_q  <= write_en_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign SerialReadEn  = read_en_q;
  assign KeyEn         = key_en_q;
  assign EncEn         = enc_en_q;
  assign DecEn         = dec_en_q;
  assign OutEn         = out_en_q;
  assign SerialWriteEn = write_en_q;
  assign ModeLatched   = mode_q;
  assign KeyValid      = key_valid_q;
  assign Busy          = busy_q;
  assign Error         = error_q;
  assign JobCount      = job_cnt_q;

endmodule
